ieee1500_wrapper_param: RTL
===========================

Name: ieee1500_wrapper_param

Overview:
- Parametrised IEEE 1500 core wrapper; next generation of the fixed 8-bit/3-bit-WIR wrapper.
- Contains a configurable-length Wrapper Boundary Register (WBR) with shift and update stages, a WIR of configurable width, and a 1-bit WBY.
- Adds CLAMP and SAFE modes, illegal-code fallback, and split input/output cell counts.
- Sits between the chip-level functional pins and one embedded core; driven by the 1500 serial control signals from the TAP/1687 network.

Parameters:
N_IN, 8, number of input boundary cells (pi -> core_in)
N_OUT, 8, number of output boundary cells (core_out -> po)
WIR_W, 3, WIR width; must be >= 3
SAFE_OUT, {N_OUT{1'b0}}, value driven on po in SAFE and INTEST

Ports:
wrck  in  1  wrapper clock; all state on rising edge
wrstn  in  1  asynchronous active-low reset
wsi  in  1  wrapper serial input
wso  out  1  wrapper serial output
selectwir  in  1  1 = WIR path, 0 = WDR path (selected by instruction)
capturewir / shiftwir / updatewir  in  1 each  WIR controls; ignored when selectwir=0
capturewdr / shiftwdr / updatewdr  in  1 each  WDR controls; ignored when selectwir=1
pi  in  N_IN  functional inputs from chip
core_in  out  N_IN  inputs to core
core_out  in  N_OUT  outputs from core
po  out  N_OUT  functional outputs to chip

Behaviour:
- Reset (async, wrstn=0):
  - wir = BYPASS, wir_sh = 0, wby = 0, wbr_sh = 0, wbr_upd = 0.
  - Outputs immediately functional: core_in = pi, po = core_out, wso = 0.
- Opcodes:
  - BYPASS = 0, EXTEST = 1, INTEST = 2, SAMPLE = 3, CLAMP = 4, SAFE = 5.
  - Any other code decodes as BYPASS.
- WIR:
  - capturewir: wir_sh <= {0..0, 2'b01}.
  - shiftwir: wir_sh <= {wsi, wir_sh[WIR_W-1:1]}.
  - updatewir: wir <= wir_sh. The new mode is visible on outputs in the cycle after the update edge.
- WDR selection:
  - WBR selected for EXTEST, INTEST, SAMPLE.
  - WBY selected for BYPASS, CLAMP, SAFE.
- WBR (L = N_IN + N_OUT):
  - wbr_sh[N_IN-1:0] are input cells; wbr_sh[L-1:N_IN] are output cells.
  - capturewdr: wbr_sh <= {core_out, pi}.
  - shiftwdr: wbr_sh <= {wsi, wbr_sh[L-1:1]}. A value shifted LSB-first for L cycles lands as written.
  - updatewdr: wbr_upd <= wbr_sh, only when WBR is selected; otherwise wbr_upd holds.
- WBY:
  - capture: wby <= 0.
  - shift: wby <= wsi. This gives a one-cycle serial delay.
- wso (combinational):
  - wir_sh[0] when selectwir=1.
  - Otherwise wbr_sh[0] or wby, per the selected WDR.
- Output muxing (combinational from wir and wbr_upd):
  - EXTEST: po = wbr_upd[L-1:N_IN], core_in = pi.
  - INTEST: core_in = wbr_upd[N_IN-1:0], po = SAFE_OUT.
  - CLAMP: po = wbr_upd[L-1:N_IN], core_in = pi. wbr_upd is frozen because WBY is selected.
  - SAFE: po = SAFE_OUT, core_in = pi.
  - BYPASS / SAMPLE / illegal: core_in = pi, po = core_out.
- Simultaneous controls:
  - capture has priority over shift on the same register.
  - update samples the pre-edge shift-stage value.
  - Control asserted on the unselected path has no effect.
- Reset mid-shift or mid-update: all state clears at once; no partial update is retained.
- No clock gating. Single clock domain.

Decomposition:
- ieee1500_pkg:
  - instruction opcode localparams and an enum type sized WIR_W.
  - WIR capture constant.
  - function decode_wdr_sel(opcode) returning WBR/WBY.
- Sub-module ieee1500_wbr: parametrised (N_IN, N_OUT) shift + update register with capture mux. The wrapper instantiates it once.

Test Plan (N_IN = N_OUT = 8, WIR_W = 3):
1. Reset while shifting the WBR, pi = 8'h3C, core_out = 8'h96: wrstn low -> core_in = 8'h3C, po = 8'h96, wso = 0. After release, IR reads BYPASS.
2. EXTEST: load 001, shift 16'hA55A LSB-first, update -> po = 8'hA5, core_in = pi. Before updatewdr, po is unchanged.
3. INTEST: load 010, shift and update 16'h5AA5 -> core_in = 8'hA5, po = SAFE_OUT = 8'h00. Then with core_out = 8'hC3, pi = 8'h55: capture, shift 16 -> wso stream reads 16'hC355.
4. WIR capture/BYPASS: capturewir then shift 3 -> wso reads 1,0,0. Load 111 (illegal) -> behaves as BYPASS; wsi 1,1,0,0 -> wso 0,1,1,0.
5. CLAMP: preload via EXTEST 16'h0F00, then load 100 -> po = 8'h0F held. A 16-bit WDR shift does not change po, and the WDR path length is 1.
6. SAFE with simultaneous capturewdr + shiftwdr: load 101 -> po = 8'h00, core_in = pi. Re-run EXTEST with capture and shift on the same edge -> the capture value wins.

Source files
------------

// File: rtl/ieee1500_pkg.sv
// rtl/ieee1500_pkg.sv - IEEE 1500 wrapper opcodes, WIR capture constant and WDR select decode
package ieee1500_pkg;

    localparam int OP_W       = 3;
    localparam int OP_N_LEGAL = 6;

    typedef enum logic [OP_W-1:0] {
        OP_BYPASS = 3'd0,
        OP_EXTEST = 3'd1,
        OP_INTEST = 3'd2,
        OP_SAMPLE = 3'd3,
        OP_CLAMP  = 3'd4,
        OP_SAFE   = 3'd5
    } opcode_e;

    typedef enum logic {
        WDR_WBY = 1'b0,
        WDR_WBR = 1'b1
    } wdr_sel_e;

    localparam logic [1:0] WIR_CAPTURE = 2'b01;

    function automatic wdr_sel_e decode_wdr_sel(input opcode_e op);
        case (op)
            OP_EXTEST, OP_INTEST, OP_SAMPLE: decode_wdr_sel = WDR_WBR;
            default:                         decode_wdr_sel = WDR_WBY;
        endcase
    endfunction

endpackage

// File: rtl/ieee1500_wrapper_param_wbr.sv
// rtl/ieee1500_wrapper_param_wbr.sv - wrapper boundary register: capture/shift stage plus update stage
module ieee1500_wbr #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    capture_i,
    input  logic                    shift_i,
    input  logic                    update_i,
    input  logic                    si_i,
    input  logic [N_IN-1:0]         pi_i,
    input  logic [N_OUT-1:0]        core_out_i,
    output logic                    so_o,
    output logic [N_IN+N_OUT-1:0]   upd_o
);

    localparam int L = N_IN + N_OUT;

    logic [L-1:0] sh_q, sh_d;
    logic [L-1:0] upd_q, upd_d;

    // capture wins over shift; update copies the pre-edge shift stage
    always_comb begin
        sh_d  = sh_q;
        upd_d = upd_q;
        if (capture_i) begin
            sh_d = {core_out_i, pi_i};
        end else if (shift_i) begin
            sh_d = {si_i, sh_q[L-1:1]};
        end
        if (update_i) begin
            upd_d = sh_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh_q  <= '0;
            upd_q <= '0;
        end else begin
            sh_q  <= sh_d;
            upd_q <= upd_d;
        end
    end

    assign so_o  = sh_q[0];
    assign upd_o = upd_q;

endmodule

// File: rtl/ieee1500_wrapper_param.sv
// rtl/ieee1500_wrapper_param.sv - parametrised IEEE 1500 core wrapper with WIR, WBY and WBR
module ieee1500_wrapper_param
    import ieee1500_pkg::*;
#(
    parameter int               N_IN     = 8,
    parameter int               N_OUT    = 8,
    parameter int               WIR_W    = 3,
    parameter logic [N_OUT-1:0] SAFE_OUT = '0
) (
    input  logic             wrck,
    input  logic             wrstn,
    input  logic             wsi,
    output logic             wso,
    input  logic             selectwir,
    input  logic             capturewir,
    input  logic             shiftwir,
    input  logic             updatewir,
    input  logic             capturewdr,
    input  logic             shiftwdr,
    input  logic             updatewdr,
    input  logic [N_IN-1:0]  pi,
    output logic [N_IN-1:0]  core_in,
    input  logic [N_OUT-1:0] core_out,
    output logic [N_OUT-1:0] po
);

    localparam logic [WIR_W-1:0] WIR_LEGAL_LIM = WIR_W'(OP_N_LEGAL);

    logic [WIR_W-1:0]       wir_q, wir_d;
    logic [WIR_W-1:0]       wir_sh_q, wir_sh_d;
    logic                   wby_q, wby_d;
    opcode_e                op;
    logic                   wbr_sel;
    logic                   wbr_so;
    logic [N_IN+N_OUT-1:0]  wbr_upd;

    // codes at or above the legal range (including any upper WIR bits) fall back to BYPASS
    always_comb begin
        op = OP_BYPASS;
        if (wir_q < WIR_LEGAL_LIM) begin
            op = opcode_e'(wir_q[OP_W-1:0]);
        end
    end

    assign wbr_sel = (decode_wdr_sel(op) == WDR_WBR);

    always_comb begin
        wir_sh_d = wir_sh_q;
        wir_d    = wir_q;
        wby_d    = wby_q;
        if (selectwir) begin
            if (capturewir) begin
                wir_sh_d = WIR_W'(WIR_CAPTURE);
            end else if (shiftwir) begin
                wir_sh_d = {wsi, wir_sh_q[WIR_W-1:1]};
            end
            if (updatewir) begin
                wir_d = wir_sh_q;
            end
        end else if (!wbr_sel) begin
            if (capturewdr) begin
                wby_d = 1'b0;
            end else if (shiftwdr) begin
                wby_d = wsi;
            end
        end
    end

    always_ff @(posedge wrck or negedge wrstn) begin
        if (!wrstn) begin
            wir_q    <= WIR_W'(OP_BYPASS);
            wir_sh_q <= '0;
            wby_q    <= 1'b0;
        end else begin
            wir_q    <= wir_d;
            wir_sh_q <= wir_sh_d;
            wby_q    <= wby_d;
        end
    end

    ieee1500_wbr #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_wbr (
        .clk_i      (wrck),
        .rst_n_i    (wrstn),
        .capture_i  (capturewdr && !selectwir && wbr_sel),
        .shift_i    (shiftwdr   && !selectwir && wbr_sel),
        .update_i   (updatewdr  && !selectwir && wbr_sel),
        .si_i       (wsi),
        .pi_i       (pi),
        .core_out_i (core_out),
        .so_o       (wbr_so),
        .upd_o      (wbr_upd)
    );

    assign wso = selectwir ? wir_sh_q[0] : (wbr_sel ? wbr_so : wby_q);

    always_comb begin
        core_in = pi;
        po      = core_out;
        case (op)
            OP_EXTEST, OP_CLAMP: po = wbr_upd[N_IN+N_OUT-1:N_IN];
            OP_INTEST: begin
                core_in = wbr_upd[N_IN-1:0];
                po      = SAFE_OUT;
            end
            OP_SAFE:   po = SAFE_OUT;
            default:   ;
        endcase
    end

endmodule
